// File: rtl/clk_div.sv
// Programmable integer clock divider with even/odd ratios.
// Ratios 0 and 1, or a deasserted enable, pass the reference clock straight through.
module clk_div #(
  parameter int unsigned RATIO_WIDTH = 8
) (
  input  logic                   i_ref_clk,
  input  logic                   i_rst_n,
  input  logic                   i_clk_en,
  input  logic [RATIO_WIDTH-1:0] i_div_ratio,
  output logic                   o_div_clk
);

  localparam logic [RATIO_WIDTH-1:0] ZERO = {RATIO_WIDTH{1'b0}};
  localparam logic [RATIO_WIDTH-1:0] ONE  = {{(RATIO_WIDTH-1){1'b0}}, 1'b1};

  // Low phase takes the extra cycle of an odd ratio; the max ratio still fits in RATIO_WIDTH bits.
  function automatic logic [RATIO_WIDTH-1:0] low_len(input logic [RATIO_WIDTH-1:0] n);
    return (n >> 1) + {{(RATIO_WIDTH-1){1'b0}}, n[0]};
  endfunction

  function automatic logic [RATIO_WIDTH-1:0] high_len(input logic [RATIO_WIDTH-1:0] n);
    return n >> 1;
  endfunction

  logic                   div_active_s;
  logic [RATIO_WIDTH-1:0] phase_len_s;
  logic [RATIO_WIDTH-1:0] cnt_r;
  logic [RATIO_WIDTH-1:0] cnt_nxt_s;
  logic                   div_reg_r;
  logic                   div_reg_nxt_s;

  assign div_active_s = i_clk_en && (i_div_ratio != ZERO) && (i_div_ratio != ONE);

  // Next phase/count; >= lets a mid-phase ratio reduction toggle at once instead of wrapping.
  always_comb begin
    cnt_nxt_s     = cnt_r;
    div_reg_nxt_s = div_reg_r;
    phase_len_s   = div_reg_r ? high_len(i_div_ratio) : low_len(i_div_ratio);
    if (!div_active_s) begin
      cnt_nxt_s     = ZERO;
      div_reg_nxt_s = 1'b0;
    end else if (cnt_r >= (phase_len_s - ONE)) begin
      cnt_nxt_s     = ZERO;
      div_reg_nxt_s = ~div_reg_r;
    end else begin
      cnt_nxt_s     = cnt_r + ONE;
    end
  end

  // Phase and counter registers with synchronous active-low reset.
  always_ff @(posedge i_ref_clk) begin
    if (!i_rst_n) begin
      cnt_r     <= ZERO;
      div_reg_r <= 1'b0;
    end else begin
      cnt_r     <= cnt_nxt_s;
      div_reg_r <= div_reg_nxt_s;
    end
  end

  // Bypass must be the raw reference clock, so this mux stays combinational.
  assign o_div_clk = div_active_s ? div_reg_r : i_ref_clk;

endmodule

// File: tb/tb_clk_div.sv
// Self-checking bench for clk_div: directed scenarios plus randomized ratio segments
// checked against an arithmetic model of the divided waveform.
module tb_clk_div;

  logic       ref_clk;
  logic       rst_n;
  logic       clk_en;
  logic [7:0] div_ratio;
  logic       div_clk;

  int n_checks = 0;
  int n_fails  = 0;

  clk_div #(.RATIO_WIDTH(8)) dut (
    .i_ref_clk  (ref_clk),
    .i_rst_n    (rst_n),
    .i_clk_en   (clk_en),
    .i_div_ratio(div_ratio),
    .o_div_clk  (div_clk)
  );

  initial begin
    ref_clk = 1'b0;
    forever #5 ref_clk = ~ref_clk;
  end

  // Output level after edge number idx of a clean run at ratio n: low for ceil(n/2) edges, then high.
  function automatic logic model_level(input int n, input int idx);
    return ((idx % n) >= ((n + 1) / 2)) ? 1'b1 : 1'b0;
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Checks `cycles` edges of a divided clock; first is the model edge index of the next rising edge.
  task automatic run_div(input string tag, input int n, input int cycles, input int first);
    for (int k = 0; k < cycles; k++) begin
      @(posedge ref_clk);
      #2;
      check(tag, div_clk, model_level(n, first + k));
    end
  endtask

  task automatic check_bypass(input string tag, input int cycles);
    for (int k = 0; k < cycles; k++) begin
      @(posedge ref_clk);
      #2;
      check(tag, div_clk, 1'b1);
      @(negedge ref_clk);
      #2;
      check(tag, div_clk, 1'b0);
    end
  endtask

  // Drops enable for one cycle so the divider restarts from a clean low phase.
  task automatic restart();
    clk_en = 1'b0;
    check_bypass("restart_bypass", 1);
  endtask

  initial begin
    int n;
    int mode;
    rst_n     = 1'b0;
    clk_en    = 1'b1;
    div_ratio = 8'd32;

    // In reset while active: output held low in both clock halves.
    for (int k = 0; k < 3; k++) begin
      @(posedge ref_clk);
      #2;
      check("rst_active_hi", div_clk, 1'b0);
      @(negedge ref_clk);
      #2;
      check("rst_active_lo", div_clk, 1'b0);
    end
    clk_en = 1'b0;
    check_bypass("rst_bypass", 2);

    // Ratio 32 after release: 16 low, 16 high.
    clk_en = 1'b1;
    rst_n  = 1'b1;
    run_div("r32", 32, 148, 1);

    // Reset during the high phase forces 0 at the resetting edge, then ratio 8.
    rst_n     = 1'b0;
    div_ratio = 8'd8;
    for (int k = 0; k < 3; k++) begin
      @(posedge ref_clk);
      #2;
      check("rst_mid", div_clk, 1'b0);
    end
    rst_n = 1'b1;
    run_div("r8", 8, 84, 1);

    // Enable dropped during the high phase: bypass is immediate.
    clk_en = 1'b0;
    #1;
    check("en_off_immediate", div_clk, 1'b1);
    check_bypass("en0_r8", 4);
    clk_en = 1'b1;
    run_div("en_r8", 8, 40, 1);

    restart();
    div_ratio = 8'd5;
    clk_en    = 1'b1;
    run_div("r5", 5, 60, 1);

    restart();
    div_ratio = 8'd3;
    clk_en    = 1'b1;
    run_div("r3", 3, 30, 1);

    div_ratio = 8'd0;
    check_bypass("r0_bypass", 4);
    div_ratio = 8'd1;
    check_bypass("r1_bypass", 4);
    div_ratio = 8'd2;
    run_div("r2", 2, 12, 1);

    restart();
    div_ratio = 8'd255;
    clk_en    = 1'b1;
    run_div("r255", 255, 300, 1);

    // 32 -> 4 in the high phase with count 3: toggles low at the next edge, then period 4.
    restart();
    div_ratio = 8'd32;
    clk_en    = 1'b1;
    run_div("chg_pre", 32, 19, 1);
    div_ratio = 8'd4;
    run_div("chg_post", 4, 24, 0);

    // Randomized segments: bypass configurations or clean divided runs.
    for (int s = 0; s < 12; s++) begin
      mode = int'($urandom_range(0, 3));
      if (mode == 0) begin
        clk_en = 1'($urandom_range(0, 1));
        if (clk_en) begin
          div_ratio = 8'($urandom_range(0, 1));
        end else begin
          div_ratio = 8'($urandom_range(0, 255));
        end
        check_bypass("rand_bypass", 3);
      end else begin
        restart();
        n = (mode == 3) ? int'($urandom_range(200, 255)) : int'($urandom_range(2, 40));
        div_ratio = 8'(n);
        clk_en    = 1'b1;
        run_div("rand_div", n, 2 * n + int'($urandom_range(0, 20)), 1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/clk_div.md
# clk_div

Programmable integer clock divider. Derives a slower clock `o_div_clk` from the reference clock `i_ref_clk` by a runtime-selectable ratio `i_div_ratio`, supporting both even and odd ratios. It sits at the clock-generation boundary and feeds downstream blocks, such as UART baud logic, that need a reduced-rate clock. When division is disabled or meaningless (ratio 0 or 1), the reference clock passes straight through.

## Interface
- `RATIO_WIDTH`, default 8: width of the division ratio input and of the internal counter.

Ports:
- `i_ref_clk`, input, 1 bit: reference clock. All state updates on its rising edge.
- `i_rst_n`, input, 1 bit: reset, synchronous and active-low.
- `i_clk_en`, input, 1 bit: divider enable.
- `i_div_ratio`, input, `RATIO_WIDTH` bits: unsigned division ratio N.
- `o_div_clk`, output, 1 bit: divided clock, or bypassed `i_ref_clk`.

## Operation
- Internal signal `div_active = i_clk_en && (i_div_ratio != 0) && (i_div_ratio != 1)`.
- Output mux: `o_div_clk = div_active ? div_reg : i_ref_clk`.
  - The mux is combinational.
  - Bypass mode is exactly the reference clock, with no register delay.
- State:
  - `div_reg`: 1-bit output phase register. 0 = low phase, 1 = high phase.
  - `cnt`: `RATIO_WIDTH`-bit cycle counter within the current phase.
- Phase lengths for ratio N:
  - Low phase length L = ceil(N/2).
  - High phase length H = floor(N/2).
  - Even N: 50% duty cycle.
  - Odd N: low phase is one reference cycle longer than high phase.
- On each rising edge of `i_ref_clk`, first match applies:
  - `!i_rst_n`: `cnt <= 0`, `div_reg <= 0`.
  - `!div_active`: `cnt <= 0`, `div_reg <= 0`. The divider is held idle so a later enable starts a clean low phase.
  - `cnt >= phase_len - 1`, where `phase_len` = L if `div_reg` = 0, else H: `div_reg <= ~div_reg`, `cnt <= 0`.
  - Otherwise: `cnt <= cnt + 1`.
- The compare uses >=, not ==. If the ratio is reduced mid-phase below the current count, the next edge toggles immediately; no wrap-around stall.
- Ratio changes while active take effect at the next phase-length compare. No reset is required.
- Half-ratio arithmetic: L = (N >> 1) + N[0], H = N >> 1, both `RATIO_WIDTH` bits.
  - N = 2^RATIO_WIDTH − 1 gives L = 2^(RATIO_WIDTH−1), which fits.
  - No overflow is possible.

## Timing
- Reset is synchronous. Register values change only on a rising edge with `i_rst_n` = 0.
- During reset with `div_active` = 1, `o_div_clk` = 0. With `div_active` = 0, `o_div_clk` follows `i_ref_clk`.
- After reset release with `div_active` = 1:
  - The first `o_div_clk` rising edge occurs L rising edges of `i_ref_clk` after the first edge with `i_rst_n` = 1.
  - The period is then exactly N reference cycles.
- `o_div_clk` transitions are aligned with the rising edge of `i_ref_clk`, delayed only by register clock-to-q.
- Enable deasserted mid-period: `o_div_clk` switches to `i_ref_clk` immediately (combinational). State clears on the next edge.
- Enable reasserted: behaves as after reset, low phase of L cycles first.
- Reset mid-operation:
  - `o_div_clk` goes to 0 at the resetting edge.
  - Division restarts from the low phase after release.

## Test plan
- Ratio 32, period 10 ns, enabled after reset: low 160 ns, high 160 ns, period 320 ns. First rise 160 ns after reset release.
- Ratio 32 → reset → ratio 8: during reset, output 0. Then period 80 ns, 40/40 ns duty.
- Ratio 5: low 30 ns, high 20 ns, period 50 ns, repeated over ≥10 periods. Ratio 3: low 20 ns, high 10 ns.
- `i_clk_en` = 0, ratio 8: `o_div_clk` identical to `i_ref_clk`. Assert enable: first rise after 4 cycles, then period 80 ns.
- Ratio 0 and ratio 1 with enable = 1: `o_div_clk` identical to `i_ref_clk`. Ratio 2: period 20 ns, 10/10 ns.
- Ratio changed 32 → 4 during a high phase with `cnt` ≥ 2: toggle on the next edge. Thereafter period 40 ns with no stall.
